alu_slice_serial: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit 181-style ALU slice.
- Executes the full 16-function logic/arithmetic table on a WIDTH-bit word, one SLICE-bit slice per clock, LSB slice first.
- The carry and group propagate/generate are chained through registers.
- Sits behind valid/ready handshakes so the datapath can trade area for latency at any word width.

---
 rtl/alu_slice_serial_pkg.sv | 28 ++
 rtl/alu_slice_serial_slice_comb.sv | 49 ++++
 rtl/alu_slice_serial.sv | 178 +++++++++++++++++
 tb/tb_alu_slice_serial.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_slice_serial_pkg.sv
// Shared types, function-select constants and the per-bit propagate/generate
// helper for the bit-serial 181-style ALU.
package alu_slice_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Commonly used function selects (S3..S0)
   localparam logic [3:0] S_PASS_A = 4'b0000;
   localparam logic [3:0] S_MINUS1 = 4'b0011;
   localparam logic [3:0] S_SUB_M1 = 4'b0110;
   localparam logic [3:0] S_ADD    = 4'b1001;

   // Per-bit {propagate, generate}. Generate is always a subset of propagate,
   // so the sum P+G needs no separate half-sum term.
   function automatic logic [1:0] bit_pg(input logic a, input logic b,
                                         input logic [3:0] s);
      logic p;
      logic g;
      p = a | (b & s[0]) | (~b & s[1]);
      g = (a & ~b & s[2]) | (a & b & s[3]);
      return {p, g};
   endfunction

endpackage

// File: rtl/alu_slice_serial_slice_comb.sv
// Combinational SLICE-bit ALU slice.
// Ports:
//   i_a, i_b   : operand slices
//   i_s, i_m   : function select and mode (1 = logic)
//   i_c        : carry into this slice (active-high)
//   i_gc       : generate-only carry into this slice (chain seeded with 0)
//   o_f        : result slice
//   o_c, o_gc  : carry / generate-only carry out of the slice
//   o_p_and    : AND of (P ^ G) over the slice
module alu_slice_comb #(
   parameter int unsigned SLICE = 4
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic [3:0]       i_s,
   input  logic             i_m,
   input  logic             i_c,
   input  logic             i_gc,
   output logic [SLICE-1:0] o_f,
   output logic             o_c,
   output logic             o_gc,
   output logic             o_p_and
);
   import alu_slice_serial_pkg::*;

   // Ripple both carry chains across the slice; G subset of P gives c' = G | P&c
   always_comb begin : slice_chain
      logic [1:0] w_pg;
      logic       w_c;
      logic       w_gc;
      logic       w_pa;
      w_pg = '0;
      w_c  = i_c;
      w_gc = i_gc;
      w_pa = 1'b1;
      o_f  = '0;
      for (int i = 0; i < int'(SLICE); i++) begin
         w_pg   = bit_pg(i_a[i], i_b[i], i_s);
         o_f[i] = i_m ? ~(w_pg[1] ^ w_pg[0]) : (w_pg[1] ^ w_pg[0] ^ w_c);
         w_c    = w_pg[0] | (w_pg[1] & w_c);
         w_gc   = w_pg[0] | (w_pg[1] & w_gc);
         w_pa   = w_pa & (w_pg[1] ^ w_pg[0]);
      end
      o_c     = w_c;
      o_gc    = w_gc;
      o_p_and = w_pa;
   end

endmodule

// File: rtl/alu_slice_serial.sv
// Bit-serial 181-style ALU: WIDTH-bit word processed SLICE bits per clock,
// LSB slice first, behind valid/ready handshakes.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake (a, b, s, m, ci_n captured on transfer)
//   out_valid/out_ready : result handshake
//   y                   : result word
//   co_n                : carry out, active-low
//   p_out, g_out        : word-level group propagate / generate
//   aeqb                : all result bits are 1
module alu_slice_serial #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             ci_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             co_n,
   output logic             p_out,
   output logic             g_out,
   output logic             aeqb
);
   import alu_slice_serial_pkg::*;

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [WIDTH-1:0] SL_MASK = WIDTH'({SLICE{1'b1}});

   state_e r_state;
   state_e w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_s;
   logic             r_m;
   logic [KW-1:0]    r_k;
   logic             r_carry;
   logic             r_gcarry;
   logic             r_prop;
   logic [WIDTH-1:0] r_y;
   logic             r_co_n;
   logic             r_p_out;
   logic             r_g_out;
   logic             r_aeqb;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_accept;
   logic             w_step;
   logic             w_last;
   logic             w_in_ready_nxt;
   logic             w_out_valid_nxt;
   logic [SLICE-1:0] w_a_sl;
   logic [SLICE-1:0] w_b_sl;
   logic [SLICE-1:0] w_f;
   logic             w_c;
   logic             w_gc;
   logic             w_pa;
   logic [WIDTH-1:0] w_y_nxt;

   // Current slice of the captured operands
   assign w_a_sl = SLICE'(r_a >> (r_k * SLICE));
   assign w_b_sl = SLICE'(r_b >> (r_k * SLICE));
   assign w_last = (r_k == KW'(NSLICE - 1));

   alu_slice_comb #(.SLICE(SLICE)) u_slice (
      .i_a     (w_a_sl),
      .i_b     (w_b_sl),
      .i_s     (r_s),
      .i_m     (r_m),
      .i_c     (r_carry),
      .i_gc    (r_gcarry),
      .o_f     (w_f),
      .o_c     (w_c),
      .o_gc    (w_gc),
      .o_p_and (w_pa)
   );

   // Result word with slice k replaced; lower slices already final
   always_comb begin
      w_y_nxt = (r_y & ~(SL_MASK << (r_k * SLICE)))
              | (WIDTH'(w_f) << (r_k * SLICE));
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
         ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   // Output/control decode; handshake flags are registered from next state
   always_comb begin
      w_accept        = 1'b0;
      w_step          = 1'b0;
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_accept        = (r_state == ST_IDLE) & in_valid;
      w_step          = (r_state == ST_RUN);
      w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
      w_out_valid_nxt = (w_state_nxt == ST_DONE);
   end

   // Operand capture, slice sequencing and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_m         <= 1'b0;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_gcarry    <= 1'b0;
         r_prop      <= 1'b1;
         r_y         <= '0;
         r_co_n      <= 1'b1;
         r_p_out     <= 1'b0;
         r_g_out     <= 1'b0;
         r_aeqb      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_s      <= s;
            r_m      <= m;
            r_k      <= '0;
            r_carry  <= ~ci_n;
            r_gcarry <= 1'b0;
            r_prop   <= 1'b1;
         end
         if (w_step) begin
            r_y      <= w_y_nxt;
            r_carry  <= w_c;
            r_gcarry <= w_gc;
            r_prop   <= r_prop & w_pa;
            r_k      <= r_k + KW'(1);
            if (w_last) begin
               r_co_n  <= ~w_c;
               r_p_out <= r_prop & w_pa;
               r_g_out <= w_gc;
               r_aeqb  <= &w_y_nxt;
            end
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign co_n      = r_co_n;
   assign p_out     = r_p_out;
   assign g_out     = r_g_out;
   assign aeqb      = r_aeqb;

endmodule

// File: tb/tb_alu_slice_serial.sv
// Self-checking bench for alu_slice_serial (WIDTH=16, SLICE=4).
module tb_alu_slice_serial;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned SLICE  = 4;
   localparam int unsigned NSLICE = WIDTH / SLICE;

   typedef struct {
      logic [15:0] y;
      logic        co_n;
      logic        p;
      logic        g;
      logic        aeqb;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  s;
      logic        m;
      logic        ci_n;
      res_t        rsp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  s;
   logic        m;
   logic        ci_n;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic        co_n;
   logic        p_out;
   logic        g_out;
   logic        aeqb;

   res_t sb_q[$];
   int   n_checks;
   int   n_errors;
   vec_t tbl[10];

   alu_slice_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .s         (s),
      .m         (m),
      .ci_n      (ci_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .co_n      (co_n),
      .p_out     (p_out),
      .g_out     (g_out),
      .aeqb      (aeqb)
   );

   always #5 clk = ~clk;

   // Word-level reference: whole-word P/G, then one wide addition
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic [3:0] ms, input logic mm,
                                  input logic mci_n);
      logic [15:0] p;
      logic [15:0] g;
      logic [16:0] sum;
      logic [16:0] gsum;
      res_t        r;
      p    = ma | (mb & {16{ms[0]}}) | (~mb & {16{ms[1]}});
      g    = (ma & ~mb & {16{ms[2]}}) | (ma & mb & {16{ms[3]}});
      gsum = {1'b0, p} + {1'b0, g};
      sum  = gsum + 17'(!mci_n);
      r.y    = mm ? ~(p ^ g) : sum[15:0];
      r.co_n = ~sum[16];
      r.p    = &(p ^ g);
      r.g    = gsum[16];
      r.aeqb = &r.y;
      return r;
   endfunction

   function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb,
                               input logic [3:0] vs, input logic vm,
                               input logic vci_n, input logic [15:0] ey,
                               input logic eco_n, input logic ep,
                               input logic eg, input logic eaeqb);
      vec_t v;
      v.a = va; v.b = vb; v.s = vs; v.m = vm; v.ci_n = vci_n;
      v.rsp.y = ey; v.rsp.co_n = eco_n; v.rsp.p = ep; v.rsp.g = eg;
      v.rsp.aeqb = eaeqb;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic check_res(input string tag, input res_t e);
      check({tag, ".y"},    32'(y),     32'(e.y));
      check({tag, ".co_n"}, 32'(co_n),  32'(e.co_n));
      check({tag, ".p"},    32'(p_out), 32'(e.p));
      check({tag, ".g"},    32'(g_out), 32'(e.g));
      check({tag, ".aeqb"}, 32'(aeqb),  32'(e.aeqb));
   endtask

   // Pop the scoreboard and compare against the presented result
   task automatic compare_out(input string tag);
      res_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s.sb: got unexpected result expected none", tag);
      end else begin
         e = sb_q.pop_front();
         check_res(tag, e);
      end
   endtask

   task automatic start_op(input string tag, input vec_t v);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      a = v.a; b = v.b; s = v.s; m = v.m; ci_n = v.ci_n;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb_q.push_back(v.rsp);
   endtask

   task automatic wait_valid(input string tag);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(NSLICE));
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      start_op(tag, v);
      wait_valid(tag);
      if (out_valid) compare_out(tag);
      @(posedge clk); #1;
      check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, ".in_ready_back"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      vec_t v;
      int   idle_bad;
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; s = '0; m = 1'b0; ci_n = 1'b1;
      n_checks = 0; n_errors = 0;

      //          a        b        s        m     ci_n  y        co_n  p     g     aeqb
      tbl[0] = mk(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[1] = mk(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
      tbl[2] = mk(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      tbl[3] = mk(16'hFFFF, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      tbl[4] = mk(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[5] = mk(16'h00FF, 16'h0000, 4'b0000, 1'b1, 1'b1, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[6] = mk(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[7] = mk(16'h1234, 16'h5678, 4'b0011, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
      tbl[8] = mk(16'h8001, 16'h1234, 4'b1111, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[9] = mk(16'h8001, 16'h1234, 4'b1111, 1'b1, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst.in_ready",  32'(in_ready),  32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.y",         32'(y),         32'd0);
      check("rst.co_n",      32'(co_n),      32'd1);
      check("rst.p",         32'(p_out),     32'd0);
      check("rst.g",         32'(g_out),     32'd0);
      check("rst.aeqb",      32'(aeqb),      32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i]);
      end

      // Random operations against the word-level model
      for (int i = 0; i < 24; i++) begin
         v.a = 16'($urandom); v.b = 16'($urandom);
         v.s = 4'($urandom); v.m = 1'($urandom); v.ci_n = 1'($urandom);
         v.rsp = model(v.a, v.b, v.s, v.m, v.ci_n);
         run_vec($sformatf("rnd%0d", i), v);
      end

      // Backpressure: result held, busy requests ignored
      out_ready = 1'b0;
      v = tbl[0];
      start_op("bp", v);
      wait_valid("bp");
      for (int i = 0; i < 5; i++) begin
         a = 16'hAAAA; b = 16'h5555; s = 4'b1001; m = 1'b0; ci_n = 1'b0;
         in_valid = 1'b1;
         if (sb_q.size() != 0) check_res($sformatf("bp_hold%0d", i), sb_q[0]);
         check($sformatf("bp_hold%0d.out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp_hold%0d.in_ready", i),  32'(in_ready),  32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      compare_out("bp_release");
      @(posedge clk); #1;
      check("bp.out_valid_drop", 32'(out_valid), 32'd0);
      check("bp.in_ready_back",  32'(in_ready),  32'd1);
      idle_bad = 0;
      for (int i = 0; i < int'(NSLICE) + 2; i++) begin
         if (out_valid) idle_bad++;
         @(posedge clk); #1;
      end
      check("bp.no_queued_op", 32'(idle_bad), 32'd0);

      // Reset on the 2nd RUN cycle aborts the operation
      start_op("rstrun", tbl[8]);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rstrun.out_valid", 32'(out_valid), 32'd0);
      check("rstrun.in_ready",  32'(in_ready),  32'd1);
      check("rstrun.y",         32'(y),         32'd0);
      check("rstrun.co_n",      32'(co_n),      32'd1);
      rst_n = 1'b1;
      sb_q.delete();
      idle_bad = 0;
      for (int i = 0; i < int'(NSLICE) + 2; i++) begin
         @(posedge clk); #1;
         if (out_valid) idle_bad++;
      end
      check("rstrun.no_output", 32'(idle_bad), 32'd0);
      run_vec("after_rst", tbl[4]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
